// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout and FSM states.
// Used by icache_direct and icache_frames; the ICACHE_STATS_EN build needs nothing extra from here.
package icache_direct_pkg;

  localparam int ISETS_DEF = 16;
  localparam int IIDX_W    = $clog2(ISETS_DEF);
  localparam int ITAG_W    = 30 - IIDX_W;
  // Stored tag field is sized for the smallest legal cache (SETS=2) and zero-extended otherwise.
  localparam int FTAG_W    = 29;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [FTAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic icache_frame_t make_frame(input logic [FTAG_W-1:0] tag,
                                               input logic [31:0] data);
    icache_frame_t f;
    f.valid = 1'b1;
    f.tag   = tag;
    f.data  = data;
    return f;
  endfunction

endpackage

// File: rtl/icache_direct_frames.sv
// Frame storage for icache_direct: one combinational read port and one synchronous write port.
// Reset clears every frame, so no stale valid bit survives a reset taken mid-fill.
module icache_frames
  import icache_direct_pkg::*;
#(
  parameter int SETS = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [IDX_W-1:0] idx,
  output icache_frame_t rframe,
  input  logic [IDX_W-1:0] widx,
  input  logic          wen,
  input  icache_frame_t frame
);

  icache_frame_t frames_r [SETS];

  assign rframe = frames_r[idx];

  // Frame array: async clear, single write per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) begin
        frames_r[i] <= '0;
      end
    end else if (wen) begin
      frames_r[widx] <= frame;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word fill on a miss.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);

  icache_state_t     state_r, state_s;
  logic [29:0]       maddr_r, maddr_s;
  logic [IDX_W-1:0]  ridx_s;
  logic [FTAG_W-1:0] rtag_s;
  logic [IDX_W-1:0]  widx_s;
  logic [FTAG_W-1:0] wtag_s;
  icache_frame_t     rframe_s, wframe_s;
  logic              hit_s, wen_s;
  logic              unused_s;

  assign ridx_s   = imemaddr[IDX_W+1:2];
  assign rtag_s   = FTAG_W'(imemaddr[31:IDX_W+2]);
  assign widx_s   = maddr_r[IDX_W-1:0];
  assign wtag_s   = FTAG_W'(maddr_r[29:IDX_W]);
  assign wframe_s = make_frame(wtag_s, iload);
  assign hit_s    = imemREN & rframe_s.valid & (rframe_s.tag == rtag_s);
  assign unused_s = ^imemaddr[1:0];

  icache_frames #(.SETS(SETS)) u_frames (
    .CLK    (CLK),
    .RST    (RST),
    .idx    (ridx_s),
    .rframe (rframe_s),
    .widx   (widx_s),
    .wen    (wen_s),
    .frame  (wframe_s)
  );

  // State and latched miss address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      maddr_r <= 30'h0;
    end else begin
      state_r <= state_s;
      maddr_r <= maddr_s;
    end
  end

  // Next state, fill strobe and fetch/memory outputs; FETCH always finishes its handshake.
  always_comb begin
    state_s  = state_r;
    maddr_s  = maddr_r;
    wen_s    = 1'b0;
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    case (state_r)
      IDLE: begin
        ihit = hit_s;
        if (hit_s) begin
          imemload = rframe_s.data;
        end else begin
          imemload = 32'h0;
        end
        if (imemREN && !hit_s) begin
          state_s = FETCH;
          maddr_s = imemaddr[31:2];
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {maddr_r, 2'b00};
        if (!iwait) begin
          wen_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = FETCH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_r, miss_count_r;

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Saturating access statistics; a miss is counted on entry to FETCH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count_r  <= 32'h0;
      miss_count_r <= 32'h0;
    end else begin
      if (ihit && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if ((state_r == IDLE) && (state_s == FETCH) && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; memory returns addr ^ 0x2001_0045.
// Build with ICACHE_STATS_EN defined to also exercise the statistics counters.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  icache_direct #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2001_0045;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic miss_detect(input logic [31:0] addr);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0)
      $display("FAIL miss_detect %h: ihit=%b iREN=%b imemload=%h, want 0/0/0", addr, ihit, iREN, imemload);
    else pass_cnt++;
    cyc();
  endtask

  task automatic fetch_phase(input logic [31:0] faddr, input int nwait,
                             input logic [31:0] naddr, input logic nren);
    for (int k = 0; k <= nwait; k++) begin
      imemaddr = naddr;
      imemREN  = nren;
      iwait    = (k < nwait) ? 1'b1 : 1'b0;
      iload    = (k < nwait) ? 32'hDEAD_BEEF : mem_word(faddr);
      @(negedge CLK);
      total_cnt++;
      if (iREN !== 1'b1 || iaddr !== faddr || ihit !== 1'b0)
        $display("FAIL fetch_req %h cyc%0d: iREN=%b iaddr=%h ihit=%b, want 1/%h/0", faddr, k, iREN, iaddr, ihit, faddr);
      else pass_cnt++;
      cyc();
    end
    iwait = 1'b1;
    iload = 32'h0;
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] word);
    imemREN  = 1'b1;
    imemaddr = addr;
    @(negedge CLK);
    total_cnt++;
    if (ihit !== 1'b1 || imemload !== word || iREN !== 1'b0)
      $display("FAIL hit %h: ihit=%b imemload=%h iREN=%b, want 1/%h/0", addr, ihit, imemload, iREN, word);
    else pass_cnt++;
    cyc();
  endtask

  task automatic do_miss(input logic [31:0] addr, input int nwait);
    miss_detect(addr);
    fetch_phase(addr, nwait, addr, 1'b1);
    expect_hit(addr, mem_word(addr));
  endtask

  task automatic test_reset();
    RST = 1'b1;
    imemREN = 1'b1;
    imemaddr = 32'h0000_0040;
    @(negedge CLK);
    total_cnt++;
    if (ihit !== 1'b0 || imemload !== 32'h0)
      $display("FAIL reset_fetch: ihit=%b imemload=%h, want 0/0", ihit, imemload);
    else pass_cnt++;
    total_cnt++;
    if (iREN !== 1'b0 || iaddr !== 32'h0)
      $display("FAIL reset_mem: iREN=%b iaddr=%h, want 0/0", iREN, iaddr);
    else pass_cnt++;
    imemREN = 1'b0;
    cyc();
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_cold_miss();
    do_miss(32'h0000_0040, 2);
  endtask

  task automatic test_warm_hit();
    expect_hit(32'h0000_0040, 32'h2001_0005);
    expect_hit(32'h0000_0042, 32'h2001_0005);
    imemREN = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0)
      $display("FAIL no_request: ihit=%b imemload=%h iREN=%b, want 0/0/0", ihit, imemload, iREN);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_conflict();
    do_miss(32'h0000_0440, 1);
    do_miss(32'h0000_0040, 0);
  endtask

  task automatic test_redirect();
    miss_detect(32'h0000_0084);
    fetch_phase(32'h0000_0084, 2, 32'h0000_00C8, 1'b1);
    miss_detect(32'h0000_00C8);
    fetch_phase(32'h0000_00C8, 1, 32'h0000_00C8, 1'b1);
    expect_hit(32'h0000_00C8, mem_word(32'h0000_00C8));
    expect_hit(32'h0000_0084, mem_word(32'h0000_0084));
  endtask

  task automatic test_ren_drop();
    miss_detect(32'h0000_0104);
    fetch_phase(32'h0000_0104, 1, 32'h0000_0104, 1'b0);
    @(negedge CLK);
    total_cnt++;
    if (ihit !== 1'b0 || iREN !== 1'b0)
      $display("FAIL ren_drop_idle: ihit=%b iREN=%b, want 0/0", ihit, iREN);
    else pass_cnt++;
    cyc();
    expect_hit(32'h0000_0104, mem_word(32'h0000_0104));
  endtask

  task automatic test_reset_mid_fetch();
    miss_detect(32'h0000_0200);
    iwait = 1'b1;
    #2;
    total_cnt++;
    if (iREN !== 1'b1)
      $display("FAIL pre_reset_fetch: iREN=%b, want 1", iREN);
    else pass_cnt++;
    RST = 1'b1;
    imemREN = 1'b0;
    #1;
    total_cnt++;
    if (iREN !== 1'b0 || iaddr !== 32'h0)
      $display("FAIL reset_mid_fetch: iREN=%b iaddr=%h, want 0/0", iREN, iaddr);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    cyc();
    do_miss(32'h0000_0040, 0);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    RST = 1'b1;
    imemREN = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0)
      $display("FAIL stats_reset: hit=%0d miss=%0d, want 0/0", hit_count, miss_count);
    else pass_cnt++;
    RST = 1'b0;
    cyc();
    do_miss(32'h0000_0040, 1);
    expect_hit(32'h0000_0040, 32'h2001_0005);
    miss_detect(32'h0000_0044);
    fetch_phase(32'h0000_0044, 0, 32'h0000_0044, 1'b0);
    @(negedge CLK);
    total_cnt++;
    if (hit_count !== 32'd2 || miss_count !== 32'd2)
      $display("FAIL stats_counts: hit=%0d miss=%0d, want 2/2", hit_count, miss_count);
    else pass_cnt++;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_redirect();
    test_ren_drop();
    test_reset_mid_fetch();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
